jit_cmd_issuer: RTL
===================

Name: jit_cmd_issuer

Overview:
- Host-side initiator for the JIT switch command stream; it is the sending end of the accelerator dispatcher.
- Converts one job descriptor into the three-word command sequence TYPEB (routing), TYPEC (config word) and TYPEA (start). Each word goes out on an AXI-Stream master.
- Waits for the 0xBABE completion word on an AXI-Stream slave, checks it and reports status.
- Only one job is in flight at a time.

Parameters:
- NUM_ACCs, 2, number of addressable accelerators; valid indices are 1..NUM_ACCs (max 8).
- TIMEOUT_CYCLES, 1024, number of WAIT_RSP cycles before a timeout is declared; 0 disables the timeout.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, synchronous, active-low.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  issuer can accept a job.
- job_acc  in  4  target accelerator index.
- job_srca  in  4  port-A source select.
- job_srcb  in  4  port-B source select.
- job_arg  in  24  argument carried in the TYPEC and TYPEA words.
- mC_tvalid  out  1  command word valid.
- mC_tready  in  1  dispatcher accepts command.
- mC_tdata  out  32  command word.
- sR_tvalid  in  1  response valid.
- sR_tready  out  1  response ready; constant 1 out of reset.
- sR_tdata  in  32  response word.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse when a job finishes.
- status  out  2  result of last job: 0 OK, 1 BADRESP, 2 TIMEOUT, 3 BADACC.
- rsp_data  out  32  last response word captured in WAIT_RSP.
- stray  out  1  one-cycle pulse when a response arrives outside WAIT_RSP.

Behaviour:
- Reset values:
  - state IDLE.
  - mC_tvalid=0, mC_tdata=0, busy=0, done=0, status=0, rsp_data=0, stray=0.
  - sR_tready=0 during reset, 1 thereafter.
  - Timeout counter=0.
- All outputs are registered; job_ready=(state==IDLE) and is not asserted while ARESETN=0.
- Command formats:
  - B = {4'hB, acc, 16'h0, srcb, srca}
  - C = {4'hC, acc, arg}
  - A = {4'hA, acc, arg}
  - Descriptor fields are latched on job handshake; later changes to job_* inputs have no effect on the job in progress.
- FSM: IDLE -> SEND_B -> SEND_C -> SEND_A -> WAIT_RSP -> REPORT -> IDLE.
- IDLE: on job_valid&job_ready:
  - If acc==0 or acc>NUM_ACCs: go to REPORT with status=3; no command is issued.
  - Otherwise go to SEND_B.
- SEND_x states:
  - mC_tvalid=1 with stable tdata until mC_tready.
  - On the handshake edge, load the next word; it is valid in the following cycle, so there is no bubble beyond the register.
  - Latency: job accepted in cycle N -> B word valid in N+1.
  - mC_tvalid is never dropped without a handshake (reset excepted).
- WAIT_RSP:
  - mC_tvalid=0; the counter increments every cycle.
  - On sR_tvalid, capture rsp_data and go to REPORT. status=0 if tdata=={16'hBABE,12'h0,acc}, else status=1.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no response: go to REPORT with status=2.
  - A response arriving in that same cycle wins, giving status 0 or 1.
- REPORT: done=1 for exactly one cycle, status updated that cycle, counter cleared, then IDLE. status holds until the next REPORT.
- busy=1 in every state except IDLE.
- A response seen in any state other than WAIT_RSP is discarded and pulses stray; this includes a late response after a timeout.
- Reset mid-job: returns to IDLE on the next edge. mC_tvalid drops, the job is lost, and no done is generated.

Optional Feature:
- Macro: JIT_ISSUER_ROUTECACHE_EN.
- Defined:
  - A per-accelerator cache holds a valid bit plus {srcb,srca}.
  - If the entry is valid and equal to the new job's selects, SEND_B is skipped and the FSM goes IDLE -> SEND_C.
  - The entry is written on the B handshake.
  - The entry is invalidated when a job to that accelerator ends with status 1 or 2.
  - All entries are invalid after reset.
- Not defined: TYPEB is always sent; no cache logic exists.

Decomposition:
- Package jit_pkg holds:
  - Type nibbles TYPE_A=4'hA, TYPE_B=4'hB, TYPE_C=4'hC.
  - RSP_MAGIC=16'hBABE.
  - Status codes ST_OK, ST_BADRESP, ST_TIMEOUT, ST_BADACC.
  - State enum for the issuer FSM.
- One sub-module, jit_wdog: loadable/clearable timeout counter with an enable. It exposes an expired flag and treats TIMEOUT_CYCLES=0 as never expiring.

Test Plan:
- Job acc=1, srca=2, srcb=3, arg=24'h00ABCD, mC_tready=1 -> words 0xB1000032, 0xC100ABCD, 0xA100ABCD in three consecutive cycles. Response 0xBABE0001 then gives done pulse, status=0, rsp_data=0xBABE0001.
- Same job with mC_tready toggling 1,0,0,1 -> each word held stable while not accepted; no word lost or duplicated.
- Job acc=2 answered with 0xBABE0001 -> status=1, rsp_data=0xBABE0001.
- TIMEOUT_CYCLES=16, no response -> done with status=2 exactly 16 cycles after entering WAIT_RSP. A later 0xBABE0002 -> stray pulse, no done.
- acc=0, then acc=3 with NUM_ACCs=2 -> status=3 each time, no mC_tvalid. Reset asserted during SEND_C -> mC_tvalid=0 next cycle, no done, job_ready=1 once ARESETN=1.
- JIT_ISSUER_ROUTECACHE_EN defined, two identical jobs to acc=1 -> second job emits only the C and A words. A third job with srca=4 re-emits the B word.

Source files
------------

// File: rtl/jit_pkg.sv
// Shared constants, status codes and FSM state type for the JIT command issuer.
package jit_pkg;

  localparam logic [3:0]  TYPE_A    = 4'hA;
  localparam logic [3:0]  TYPE_B    = 4'hB;
  localparam logic [3:0]  TYPE_C    = 4'hC;
  localparam logic [15:0] RSP_MAGIC = 16'hBABE;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BADRESP = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_BADACC  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_B,
    S_SEND_C,
    S_SEND_A,
    S_WAIT_RSP,
    S_REPORT
  } issuer_state_e;

  function automatic logic [31:0] cmdWordB(input logic [3:0] acc, input logic [3:0] srcb,
                                           input logic [3:0] srca);
    return {TYPE_B, acc, 16'h0, srcb, srca};
  endfunction

  function automatic logic [31:0] cmdWordArg(input logic [3:0] typ, input logic [3:0] acc,
                                             input logic [23:0] arg);
    return {typ, acc, arg};
  endfunction

endpackage

// File: rtl/jit_wdog.sv
// Response watchdog: clearable/loadable cycle counter; TIMEOUT_CYCLES=0 never expires.
module jit_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] loadVal_i,
  input  logic        en_i,
  output logic        expired_o
);

  localparam logic [31:0] LIMIT = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (load_i) count_d = loadVal_i;
    else if (en_i)   count_d = count_q + 32'd1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) count_q <= '0;
    else          count_q <= count_d;
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/jit_cmd_issuer.sv
// Host-side JIT command issuer: job descriptor -> TYPEB/TYPEC/TYPEA words, then waits for 0xBABE.
// Optional per-accelerator route cache enabled by JIT_ISSUER_ROUTECACHE_EN.
module jit_cmd_issuer
  import jit_pkg::*;
#(
  parameter int unsigned NUM_ACCs       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [3:0]  job_acc,
  input  logic [3:0]  job_srca,
  input  logic [3:0]  job_srcb,
  input  logic [23:0] job_arg,
  output logic        mC_tvalid,
  input  logic        mC_tready,
  output logic [31:0] mC_tdata,
  input  logic        sR_tvalid,
  output logic        sR_tready,
  input  logic [31:0] sR_tdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] rsp_data,
  output logic        stray
);

  issuer_state_e state_q, state_d;
  logic [3:0]  acc_q, acc_d;
  logic [23:0] arg_q, arg_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q, tdata_d;
  logic        done_q, done_d;
  logic        stray_q, stray_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rspData_q, rspData_d;
  logic        rspReady_q;

  logic wdClr, wdEn, wdExpired;
  logic accOk, rspFire, cacheHit;

  assign accOk   = (job_acc != 4'd0) && ({28'd0, job_acc} <= NUM_ACCs);
  assign rspFire = sR_tvalid && rspReady_q;

`ifdef JIT_ISSUER_ROUTECACHE_EN
  logic [15:0] cValid_q;
  logic [7:0]  cRoute_q [16];
  logic [7:0]  route_q;

  assign cacheHit = cValid_q[job_acc] && (cRoute_q[job_acc] == {job_srcb, job_srca});

  // Entries learn the route on the B handshake and forget it when the job ends badly.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cValid_q <= '0;
    end else begin
      if (state_q == S_IDLE && job_valid) route_q <= {job_srcb, job_srca};
      if (state_q == S_SEND_B && mC_tready) begin
        cValid_q[acc_q] <= 1'b1;
        cRoute_q[acc_q] <= route_q;
      end else if (state_q == S_REPORT &&
                   (status_q == ST_BADRESP || status_q == ST_TIMEOUT)) begin
        cValid_q[acc_q] <= 1'b0;
      end
    end
  end
`else
  assign cacheHit = 1'b0;
`endif

  jit_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .clr_i     (wdClr),
    .load_i    (1'b0),
    .loadVal_i (32'd0),
    .en_i      (wdEn),
    .expired_o (wdExpired)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    arg_d     = arg_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    done_d    = 1'b0;
    stray_d   = 1'b0;
    status_d  = status_q;
    rspData_d = rspData_q;
    wdClr     = 1'b0;
    wdEn      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready) begin
          acc_d = job_acc;
          arg_d = job_arg;
          if (!accOk) begin
            state_d  = S_REPORT;
            status_d = ST_BADACC;
            done_d   = 1'b1;
          end else if (cacheHit) begin
            state_d  = S_SEND_C;
            tvalid_d = 1'b1;
            tdata_d  = cmdWordArg(TYPE_C, job_acc, job_arg);
          end else begin
            state_d  = S_SEND_B;
            tvalid_d = 1'b1;
            tdata_d  = cmdWordB(job_acc, job_srcb, job_srca);
          end
        end
      end
      S_SEND_B: begin
        if (mC_tready) begin
          state_d = S_SEND_C;
          tdata_d = cmdWordArg(TYPE_C, acc_q, arg_q);
        end
      end
      S_SEND_C: begin
        if (mC_tready) begin
          state_d = S_SEND_A;
          tdata_d = cmdWordArg(TYPE_A, acc_q, arg_q);
        end
      end
      S_SEND_A: begin
        if (mC_tready) begin
          state_d  = S_WAIT_RSP;
          tvalid_d = 1'b0;
        end
      end
      // A response in the expiry cycle takes priority over the timeout.
      S_WAIT_RSP: begin
        wdEn = 1'b1;
        if (rspFire) begin
          state_d   = S_REPORT;
          done_d    = 1'b1;
          rspData_d = sR_tdata;
          status_d  = (sR_tdata == {RSP_MAGIC, 12'h0, acc_q}) ? ST_OK : ST_BADRESP;
        end else if (wdExpired) begin
          state_d  = S_REPORT;
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
        end
      end
      S_REPORT: begin
        wdClr   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rspFire && state_q != S_WAIT_RSP) stray_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      arg_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      done_q     <= 1'b0;
      stray_q    <= 1'b0;
      status_q   <= ST_OK;
      rspData_q  <= '0;
      rspReady_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      arg_q      <= arg_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      done_q     <= done_d;
      stray_q    <= stray_d;
      status_q   <= status_d;
      rspData_q  <= rspData_d;
      rspReady_q <= 1'b1;
    end
  end

  assign job_ready = (state_q == S_IDLE) && ARESETN;
  assign mC_tvalid = tvalid_q;
  assign mC_tdata  = tdata_q;
  assign sR_tready = rspReady_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign status    = status_q;
  assign rsp_data  = rspData_q;
  assign stray     = stray_q;

endmodule
